// File: rtl/uart_tx_arbiter_if.sv
// Bundle of signals between the byte requesters, the arbiter and uart_tx.
// The master modport is the arbiter's view. The slave modport is the view of
// the surrounding logic: the requesters and the uart_tx Busy line.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_busy;
  logic [7:0]           tx_p_data;
  logic                 tx_data_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 arb_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_p_data, tx_data_valid, grant_id, arb_busy
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_p_data, tx_data_valid, grant_id, arb_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte sources.
// Each grant takes one byte. The byte is issued as a one-cycle DATA_VALID pulse.
// The next grant waits until uart_tx has raised Busy and then dropped it again.
// If Busy does not rise within BUSY_WAIT cycles, the same byte is pulsed again.
// Optional feature macro: UART_ARB_BURST_EN. When it is defined, the current
// grantee may keep the grant for up to MAX_BURST consecutive bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BUSY_WAIT = 4,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RETRY_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_next;
  logic [ID_W-1:0]    grant_id, winner, cand;
  logic [7:0]         tx_p_data, sel_byte;
  logic               tx_data_valid;
  logic [RETRY_W-1:0] retry_cnt;
  logic [NUM_REQ-1:0] req_ready;
  logic               accept;

`ifdef UART_ARB_BURST_EN
  localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BURST_W-1:0] burst_cnt;
  logic               burst_hold;
  logic               burst_again;
`endif

  // Pick the next grantee: the first valid index after the last grantee, with wrap.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave it unassigned and infer a latch.
    winner   = grant_id;
    cand     = grant_id;
    sel_byte = '0;
    // Scan from the farthest offset down to the nearest. The nearest valid index is written last, so it wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = ID_W'((int'(grant_id) + off) % NUM_REQ);
      if (bus.req_valid[cand]) winner = cand;
    end
`ifdef UART_ARB_BURST_EN
    if (burst_hold && bus.req_valid[grant_id]) winner = grant_id;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_byte = bus.req_data[8*i +: 8];
    end
  end

  // Next-state logic and the combinational ready strobe, which is asserted only in IDLE.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.tx_busy && |bus.req_valid) begin
          accept            = 1'b1;
          req_ready[winner] = 1'b1;
          state_next        = ISSUE;
        end
      end
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)                    state_next = WAIT_DONE;
        else if (retry_cnt == RETRY_LAST)   state_next = ISSUE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Latch the byte and grantee on accept. The valid pulse tracks entry into ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_p_data     <= 8'h00;
      tx_data_valid <= 1'b0;
      grant_id      <= ID_W'(NUM_REQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      tx_data_valid <= (state_next == ISSUE);
      if (accept) begin
        tx_p_data <= sel_byte;
        grant_id  <= winner;
      end
    end
  end

  // Count the cycles spent in WAIT_BUSY since the last pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  retry_cnt <= '0;
    else if (state == WAIT_BUSY) retry_cnt <= retry_cnt + RETRY_W'(1);
    else                         retry_cnt <= '0;
  end

`ifdef UART_ARB_BURST_EN
  assign burst_again = bus.req_valid[grant_id] && (burst_cnt < BURST_W'(MAX_BURST - 1));

  // Burst bookkeeping. The decision is made on the WAIT_DONE -> IDLE transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt  <= '0;
      burst_hold <= 1'b0;
    end else if (state == WAIT_DONE && state_next == IDLE) begin
      if (burst_again) begin
        burst_cnt  <= burst_cnt + BURST_W'(1);
        burst_hold <= 1'b1;
      end else begin
        burst_cnt  <= '0;
        burst_hold <= 1'b0;
      end
    end else if (accept) begin
      burst_hold <= 1'b0;
      if (!(burst_hold && bus.req_valid[grant_id])) burst_cnt <= '0;
    end
  end
`endif

  assign bus.req_ready     = req_ready;
  assign bus.tx_p_data     = tx_p_data;
  assign bus.tx_data_valid = tx_data_valid;
  assign bus.grant_id      = grant_id;
  assign bus.arb_busy      = (state != IDLE);
endmodule
